// File: rtl/arb_mux_2to1_pkg.sv
// Shared definitions for the 2:1 arbitrating mux: default payload width and
// the source encoding carried on sel and used by the round-robin pointer.
// No logic, no latency, no backpressure; types and constants only.
package arb_mux_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Source encoding: SRC_A = 0, SRC_B = 1. Reused for the priority pointer.
  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

endpackage : arb_mux_pkg

// File: rtl/arb_mux_2to1_if.sv
// Bundle of the two source channels (A, B) and the output channel (y).
// Modports: slave = the mux itself (takes a/b, drives readies and y);
//           master = the environment around it (drives a/b, consumes y).
interface arb_mux_2to1_if
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  // Source A channel
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;

  // Source B channel
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;

  // Output channel; sel names the source of the word held in y
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             y_ready;
  logic             sel;

  modport slave (
    input  a_data, a_valid, b_data, b_valid, y_ready,
    output a_ready, b_ready, y, y_valid, sel
  );

  modport master (
    output a_data, a_valid, b_data, b_valid, y_ready,
    input  a_ready, b_ready, y, y_valid, sel
  );

endinterface : arb_mux_2to1_if

// File: rtl/arb_mux_2to1_rr_arbiter_2.sv
// Two-requester round-robin arbiter: combinational grant, registered pointer.
// Latency: grant is same-cycle; pointer moves on the edge after a taken grant.
// Backpressure: pointer only advances when advance is high (grant consumed).
// Ports: clk, rst (sync, active-high); req[1:0] (bit0 = A, bit1 = B);
//        advance (grant is being taken this cycle); gnt[1:0] one-hot or zero.
module rr_arbiter_2
  import arb_mux_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // Source favoured when both request; starts at A out of reset.
  src_e prio;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (prio == SRC_A) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // The pointer flips away from whoever was served, even with a single
  // requester, so a lone winner does not keep priority once the other shows up.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= SRC_A;
    end else if (advance && gnt[0]) begin
      prio <= SRC_B;
    end else if (advance && gnt[1]) begin
      prio <= SRC_A;
    end
  end

endmodule : rr_arbiter_2

// File: rtl/arb_mux_2to1.sv
// 2:1 round-robin arbitrating mux with a single registered output stage.
// Latency: 1 cycle from accepted word to y; one word per cycle sustained.
// Backpressure: y holds while y_valid && !y_ready; both source readies drop.
// Ports: clk, rst (sync, active-high); bus.slave carries a_*/b_* sources and
//        the y/y_valid/y_ready/sel output channel.
module arb_mux_2to1
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  arb_mux_2to1_if.slave        bus
);

  logic             load_en;
  logic             advance;
  logic [1:0]       gnt;
  logic [WIDTH-1:0] y_next;

  // The output register can take a word when empty or being drained now.
  assign load_en = !bus.y_valid || bus.y_ready;

  // Gating with !rst keeps both readies low for the whole reset cycle, even
  // before y_valid has its reset value.
  assign advance = load_en && !rst;

  rr_arbiter_2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({bus.b_valid, bus.a_valid}),
    .advance (advance),
    .gnt     (gnt)
  );

  // Readies depend only on valids, y_valid, y_ready and rst -- never on data.
  assign bus.a_ready = advance && gnt[0];
  assign bus.b_ready = advance && gnt[1];

  always_comb begin
    y_next = bus.b_data;
    if (gnt[0]) begin
      y_next = bus.a_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.y       <= '0;
      bus.y_valid <= 1'b0;
      bus.sel     <= SRC_A;
    end else if (load_en) begin
      if (gnt[0] || gnt[1]) begin
        bus.y       <= y_next;
        bus.y_valid <= 1'b1;
        bus.sel     <= gnt[1] ? SRC_B : SRC_A;
      end else begin
        // Nothing to load: retire the word, keep y/sel as last seen.
        bus.y_valid <= 1'b0;
      end
    end
  end

endmodule : arb_mux_2to1

// File: doc/arb_mux_2to1.md
ARB_MUX_2TO1 -- requirements
Module: arb_mux_2to1

Interface
REQ-001 Parameter: WIDTH, default 8, data width of every data port.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 a_data  input  WIDTH  source A payload.
REQ-006 a_valid  input  1  source A holds a valid word.
REQ-007 a_ready  output  1  A word accepted this cycle when a_valid && a_ready.
REQ-008 b_data  input  WIDTH  source B payload.
REQ-009 b_valid  input  1  source B holds a valid word.
REQ-010 b_ready  output  1  B word accepted this cycle when b_valid && b_ready.
REQ-011 y  output  WIDTH  registered selected payload.
REQ-012 y_valid  output  1  y holds a word not yet consumed.
REQ-013 y_ready  input  1  downstream consumes y when y_valid && y_ready.
REQ-014 sel  output  1  source of the word in y (0 = A, 1 = B), registered with y.

Function
REQ-015 Output register "load enable" SHALL be: !y_valid || y_ready.
REQ-016 Grant SHALL be combinational: only A valid -> A; only B valid -> B; both valid -> source named by priority pointer prio (0 = A, 1 = B); neither -> no grant.
REQ-017 a_ready SHALL equal load_en && grant to A; b_ready SHALL equal load_en && grant to B; both never high together.
REQ-018 On a grant, at the next rising edge y, sel SHALL take the granted data/source and y_valid SHALL be 1 (latency 1 cycle).
REQ-019 When load_en is high and no grant, y_valid SHALL go 0; y and sel SHALL hold.
REQ-020 When y_valid && !y_ready, y, sel, y_valid SHALL hold; a_ready = b_ready = 0 (backpressure).
REQ-021 prio SHALL update only on a grant: after granting A, prio = 1; after granting B, prio = 0 (round-robin, also when only one requester).
REQ-022 Sustained throughput SHALL be one word per cycle when y_ready stays 1.
REQ-023 Both valid continuously with y_ready = 1 SHALL yield strictly alternating sel: 0,1,0,1... from reset.
REQ-024 a_ready/b_ready SHALL NOT depend on a_data/b_data; no combinational path from y_ready to y.

Reset
REQ-025 While rst = 1 at a rising edge: y_valid = 0, y = 0, sel = 0, prio = 0 (A favoured).
REQ-026 During any cycle with rst = 1, a_ready and b_ready SHALL be 0; words presented are not accepted.
REQ-027 Reset mid-transfer SHALL discard the held word in y; no word is replayed after reset.

Structure
REQ-028 Shared package arb_mux_pkg SHALL hold WIDTH default (8) and source encodings SRC_A = 0, SRC_B = 1.
REQ-029 Arbitration (REQ-016, REQ-021) SHALL be a sub-module rr_arbiter_2 (inputs req[1:0], advance, clk, rst; output gnt[1:0]); datapath register stays in arb_mux_2to1.
REQ-030 Total RTL SHALL be under 400 lines; no latches; all state in clk domain.

Verification
REQ-031 Reset: rst = 1 for 2 cycles with a_valid = b_valid = 1 -> a_ready = b_ready = 0, y_valid = 0, y = 0, sel = 0.
REQ-032 Single source: a_valid = 1, a_data = 0x3C, b_valid = 0, y_ready = 1 -> a_ready = 1; next cycle y = 0x3C, sel = 0, y_valid = 1.
REQ-033 Contention: a_data = 0x11, b_data = 0x22 both valid 4 cycles, y_ready = 1 -> y sequence 0x11, 0x22, 0x11, 0x22, sel 0,1,0,1.
REQ-034 Backpressure: y holds 0x55 from A, y_ready = 0 for 3 cycles with b_valid = 1 -> y = 0x55 stable, b_ready = 0; y_ready = 1 -> b_ready = 1, next cycle sel = 1.
REQ-035 Drain: single word in y, y_ready = 1, no valids -> next cycle y_valid = 0, y unchanged.
REQ-036 Reset mid-operation: y_valid = 1 with y = 0x7E, rst pulsed 1 cycle -> y_valid = 0, y = 0, prio = 0; next contention grants A first.
